// File: rtl/vidac_enc.sv
// vidac_enc: queues drawing commands as little-endian byte records in video
// memory, then terminates the list and kicks the accelerator.
// Build option: define VIDAC_ENC_AUTOFLUSH_EN so that a push which does not
// fit flushes the list first and then emits the held record at offset 0.
//
// state | meaning
// IDLE  | accepts push/flush, rdy=1
// EMIT  | writing one record byte per cycle
// TERM  | writing the 00 terminator
// KICK  | one-cycle start pulse, bus released
// WAITB | waiting for accelerator to go busy
// WAITD | waiting for accelerator to finish
module vidac_enc #(
  parameter int          MAXLEN = 4096,
  parameter logic [17:0] BASE   = 18'h20000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  op,
  input  logic [15:0] px1,
  input  logic [15:0] py1,
  input  logic [15:0] px2,
  input  logic [15:0] py2,
  input  logic [7:0]  pc,
  input  logic        push,
  input  logic        flush,
  output logic        rdy,
  output logic        err,
  output logic [15:0] len,
  output logic [17:0] a,
  output logic [7:0]  o,
  output logic        w,
  output logic        own,
  output logic        cmd,
  input  logic        bsy
);

  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_TERM, S_KICK, S_WAITB, S_WAITD} state_t;

  state_t      r_state;
  logic [15:0] r_ptr;
  logic [2:0]  r_op;
  logic [15:0] r_x1, r_y1, r_x2, r_y2;
  logic [7:0]  r_c;
  logic [3:0]  r_n;
  logic [3:0]  r_idx;
  logic        r_pend;
  logic        r_held;
  logic [17:0] r_a;
  logic [7:0]  r_o;
  logic        r_w, r_own, r_cmd, r_err;

  logic [3:0]  w_n_in;
  logic        w_op_ok;
  logic [16:0] w_need;
  logic        w_fits;
  logic        w_flush_req;
  logic        w_acc, w_auto, w_rej, w_term;
  logic [7:0]  w_rec [0:9];

  // record length (opcode byte included) for the incoming command
  always_comb begin
    w_n_in = 4'd0;
    case (op)
      3'd1, 3'd2, 3'd3: w_n_in = 4'd10;
      3'd4:             w_n_in = 4'd6;
      3'd5, 3'd6:       w_n_in = 4'd8;
      default:          w_n_in = 4'd0;
    endcase
  end

  // push/flush decisions while idle; pending flush counts as a flush request
  always_comb begin
    w_op_ok     = (op != 3'd0) && (op != 3'd7);
    w_need      = {1'b0, r_ptr} + {13'd0, w_n_in} + 17'd1;
    w_fits      = (w_need <= 17'(MAXLEN));
    w_flush_req = flush | r_pend;
    w_acc       = push & w_op_ok & w_fits;
`ifdef VIDAC_ENC_AUTOFLUSH_EN
    w_auto      = push & w_op_ok & ~w_fits & (r_ptr != 16'd0);
`else
    w_auto      = 1'b0;
`endif
    w_rej       = push & ~w_acc & ~w_auto;
    w_term      = w_auto | (~w_acc & w_flush_req & (r_ptr != 16'd0));
  end

  // byte image of the latched record
  always_comb begin
    for (int i = 0; i < 10; i++) w_rec[i] = 8'h00;
    w_rec[0] = {5'd0, r_op};
    case (r_op)
      3'd4: begin
        w_rec[1] = r_x2[7:0]; w_rec[2] = r_x2[15:8];
        w_rec[3] = r_y2[7:0]; w_rec[4] = r_y2[15:8];
        w_rec[5] = r_c;
      end
      3'd5, 3'd6: begin
        w_rec[1] = r_x1[7:0]; w_rec[2] = r_x1[15:8];
        w_rec[3] = r_y1[7:0]; w_rec[4] = r_y1[15:8];
        w_rec[5] = r_x2[7:0]; w_rec[6] = r_x2[15:8];
        w_rec[7] = r_c;
      end
      default: begin
        w_rec[1] = r_x1[7:0]; w_rec[2] = r_x1[15:8];
        w_rec[3] = r_y1[7:0]; w_rec[4] = r_y1[15:8];
        w_rec[5] = r_x2[7:0]; w_rec[6] = r_x2[15:8];
        w_rec[7] = r_y2[7:0]; w_rec[8] = r_y2[15:8];
        w_rec[9] = r_c;
      end
    endcase
  end

  // sequencer with registered bus outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 16'd0;
      r_op    <= 3'd0;
      r_x1    <= 16'd0; r_y1 <= 16'd0; r_x2 <= 16'd0; r_y2 <= 16'd0;
      r_c     <= 8'd0;
      r_n     <= 4'd0;
      r_idx   <= 4'd0;
      r_pend  <= 1'b0;
      r_held  <= 1'b0;
      r_a     <= 18'd0;
      r_o     <= 8'd0;
      r_w     <= 1'b0;
      r_own   <= 1'b0;
      r_cmd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_cmd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_err <= w_rej;
          if (w_acc | w_auto) begin
            r_op <= op;
            r_x1 <= px1; r_y1 <= py1; r_x2 <= px2; r_y2 <= py2;
            r_c  <= pc;
            r_n  <= w_n_in;
          end
          r_held <= w_auto;
          if (w_acc) begin
            r_state <= S_EMIT;
            r_a     <= BASE + {2'd0, r_ptr};
            r_o     <= {5'd0, op};
            r_w     <= 1'b1;
            r_own   <= 1'b1;
            r_ptr   <= r_ptr + 16'd1;
            r_idx   <= 4'd1;
            r_pend  <= w_flush_req;
          end else if (w_term) begin
            r_state <= S_TERM;
            r_a     <= BASE + {2'd0, r_ptr};
            r_o     <= 8'h00;
            r_w     <= 1'b1;
            r_own   <= 1'b1;
            r_pend  <= w_auto & w_flush_req;
          end else begin
            r_pend  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (r_idx == r_n) begin
            if (r_pend) begin
              r_state <= S_TERM;
              r_a     <= BASE + {2'd0, r_ptr};
              r_o     <= 8'h00;
              r_pend  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_w     <= 1'b0;
              r_own   <= 1'b0;
            end
          end else begin
            r_a   <= BASE + {2'd0, r_ptr};
            r_o   <= w_rec[r_idx];
            r_ptr <= r_ptr + 16'd1;
            r_idx <= r_idx + 4'd1;
          end
        end
        S_TERM: begin
          r_state <= S_KICK;
          r_w     <= 1'b0;
          r_own   <= 1'b0;
          r_cmd   <= 1'b1;
        end
        S_KICK: r_state <= S_WAITB;
        S_WAITB: if (bsy) r_state <= S_WAITD;
        S_WAITD: begin
          if (!bsy) begin
            if (r_held) begin
              // replay the command that did not fit, now at the buffer start
              r_held  <= 1'b0;
              r_state <= S_EMIT;
              r_a     <= BASE;
              r_o     <= {5'd0, r_op};
              r_w     <= 1'b1;
              r_own   <= 1'b1;
              r_ptr   <= 16'd1;
              r_idx   <= 4'd1;
            end else begin
              r_state <= S_IDLE;
              r_ptr   <= 16'd0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdy = (r_state == S_IDLE);
  assign err = r_err;
  assign len = r_ptr;
  assign a   = r_a;
  assign o   = r_o;
  assign w   = r_w;
  assign own = r_own;
  assign cmd = r_cmd;

endmodule

// File: tb/tb_vidac_enc.sv
// Scoreboard bench for vidac_enc (buffer capacity 16 bytes).
module tb_vidac_enc;
  localparam int          MAXLEN = 16;
  localparam logic [17:0] BASE   = 18'h20000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] px1 = 16'd0, py1 = 16'd0, px2 = 16'd0, py2 = 16'd0;
  logic [7:0]  pc = 8'd0;
  logic        push = 1'b0, flush = 1'b0, bsy = 1'b0;
  logic        rdy, err, w, own, cmd;
  logic [15:0] len;
  logic [17:0] a;
  logic [7:0]  o;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  int          err_cnt = 0;
  int          cmd_cnt = 0;
  int          e0, c0;
  logic        prev_cmd = 1'b0;
  logic [25:0] exp_q [$];

  vidac_enc #(.MAXLEN(MAXLEN), .BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n), .op(op),
    .px1(px1), .py1(py1), .px2(px2), .py2(py2), .pc(pc),
    .push(push), .flush(flush), .rdy(rdy), .err(err), .len(len),
    .a(a), .o(o), .w(w), .own(own), .cmd(cmd), .bsy(bsy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back({BASE + 18'(m_ptr), b});
    m_ptr++;
  endtask

  task automatic exp_rec(input logic [2:0] opc, input logic [15:0] x1, input logic [15:0] y1,
                         input logic [15:0] x2, input logic [15:0] y2, input logic [7:0] c);
    exp_byte({5'd0, opc});
    if (opc == 3'd4) begin
      exp_byte(x2[7:0]); exp_byte(x2[15:8]); exp_byte(y2[7:0]); exp_byte(y2[15:8]);
    end else if (opc == 3'd5 || opc == 3'd6) begin
      exp_byte(x1[7:0]); exp_byte(x1[15:8]); exp_byte(y1[7:0]); exp_byte(y1[15:8]);
      exp_byte(x2[7:0]); exp_byte(x2[15:8]);
    end else begin
      exp_byte(x1[7:0]); exp_byte(x1[15:8]); exp_byte(y1[7:0]); exp_byte(y1[15:8]);
      exp_byte(x2[7:0]); exp_byte(x2[15:8]); exp_byte(y2[7:0]); exp_byte(y2[15:8]);
    end
    exp_byte(c);
  endtask

  // terminator at the current offset; the list then restarts at 0
  task automatic exp_term();
    exp_q.push_back({BASE + 18'(m_ptr), 8'h00});
    m_ptr = 0;
  endtask

  task automatic drive(input logic [2:0] opc, input logic [15:0] x1, input logic [15:0] y1,
                       input logic [15:0] x2, input logic [15:0] y2, input logic [7:0] c,
                       input logic fl);
    @(negedge clock);
    op = opc; px1 = x1; py1 = y1; px2 = x2; py2 = y2; pc = c;
    push = 1'b1; flush = fl;
    @(negedge clock);
    push = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (rdy) break;
    end
    chk(tag, 32'(rdy), 1);
  endtask

  task automatic wait_cmd(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (cmd) break;
    end
    chk(tag, 32'(cmd), 1);
  endtask

  task automatic kick_bsy(input int cyc);
    wait_cmd("kick_seen");
    bsy = 1'b1;
    repeat (cyc) @(negedge clock);
    bsy = 1'b0;
    wait_rdy("kick_done");
  endtask

  // write scoreboard and bus invariants
  always @(negedge clock) begin
    if (reset_n) begin
      if (w) begin
        if (exp_q.size() == 0) chk("wr_unexp", 32'(exp_q.size()), 1);
        else chk("wr", 32'({a, o}), 32'(exp_q.pop_front()));
      end
      chk("w_no_own", 32'(w & ~own), 0);
      chk("w_bsy", 32'(w & bsy), 0);
      chk("cmd_dbl", 32'(cmd & prev_cmd), 0);
      if (err) err_cnt++;
      if (cmd) cmd_cnt++;
    end
    prev_cmd = cmd;
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_len", 32'(len), 0);
    chk("rst_w", 32'(w), 0);
    chk("rst_own", 32'(own), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_o", 32'(o), 0);
    reset_n = 1'b1;

    // LINE, plus a push during EMIT that must be ignored
    e0 = err_cnt;
    exp_rec(3'd1, 16'd1, 16'd2, 16'd300, 16'hFFFB, 8'h0F);
    drive(3'd1, 16'd1, 16'd2, 16'd300, 16'hFFFB, 8'h0F, 1'b0);
    drive(3'd2, 16'd9, 16'd9, 16'd9, 16'd9, 8'h55, 1'b0);
    wait_rdy("line_rdy");
    chk("line_len", 32'(len), 10);
    chk("line_q", 32'(exp_q.size()), 0);
    chk("ign_err", 32'(err_cnt - e0), 0);

    // flush with 50 busy cycles
    c0 = cmd_cnt;
    exp_term();
    do_flush();
    kick_bsy(50);
    chk("flush_len", 32'(len), 0);
    chk("flush_cmd", 32'(cmd_cnt - c0), 1);

    // CIRCLE, then POLY with a same-cycle flush
    exp_rec(3'd5, 16'd160, 16'd100, 16'd40, 16'd0, 8'd7);
    drive(3'd5, 16'd160, 16'd100, 16'd40, 16'd0, 8'd7, 1'b0);
    wait_rdy("circ_rdy");
    chk("circ_len", 32'(len), 8);
    exp_rec(3'd4, 16'h1111, 16'h2222, 16'd10, 16'd20, 8'd3);
    exp_term();
    drive(3'd4, 16'h1111, 16'h2222, 16'd10, 16'd20, 8'd3, 1'b1);
    kick_bsy(10);
    chk("poly_len", 32'(len), 0);
    chk("poly_q", 32'(exp_q.size()), 0);

    // illegal opcodes
    for (int k = 0; k < 2; k++) begin
      e0 = err_cnt;
      drive((k == 0) ? 3'd0 : 3'd7, 16'd1, 16'd1, 16'd1, 16'd1, 8'd1, 1'b0);
      @(negedge clock);
      chk("badop_err", 32'(err_cnt - e0), 1);
      chk("badop_len", 32'(len), 0);
      chk("badop_rdy", 32'(rdy), 1);
    end

    // overflow: second LINE does not fit in 16 bytes
    exp_rec(3'd2, 16'd5, 16'd6, 16'd7, 16'd8, 8'hAA);
    drive(3'd2, 16'd5, 16'd6, 16'd7, 16'd8, 8'hAA, 1'b0);
    wait_rdy("ovf_rdy1");
    chk("ovf_len1", 32'(len), 10);
    e0 = err_cnt;
`ifdef VIDAC_ENC_AUTOFLUSH_EN
    exp_term();
    exp_rec(3'd1, 16'd11, 16'd12, 16'd13, 16'd14, 8'hBB);
    drive(3'd1, 16'd11, 16'd12, 16'd13, 16'd14, 8'hBB, 1'b0);
    kick_bsy(20);
    wait_rdy("af_rdy");
    chk("af_err", 32'(err_cnt - e0), 0);
    chk("af_len", 32'(len), 10);
`else
    drive(3'd1, 16'd11, 16'd12, 16'd13, 16'd14, 8'hBB, 1'b0);
    @(negedge clock);
    chk("ovf_err", 32'(err_cnt - e0), 1);
    chk("ovf_len2", 32'(len), 10);
    chk("ovf_rdy2", 32'(rdy), 1);
`endif
    exp_term();
    do_flush();
    kick_bsy(5);
    chk("ovf_clr", 32'(len), 0);

    // reset while waiting for the accelerator to finish
    exp_rec(3'd4, 16'd0, 16'd0, 16'd3, 16'd4, 8'h11);
    exp_term();
    drive(3'd4, 16'd0, 16'd0, 16'd3, 16'd4, 8'h11, 1'b1);
    wait_cmd("wd_cmd");
    bsy = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("wd_cmd0", 32'(cmd), 0);
    chk("wd_own0", 32'(own), 0);
    chk("wd_rdy", 32'(rdy), 1);
    chk("wd_len", 32'(len), 0);
    reset_n = 1'b1;
    bsy = 1'b0;
    repeat (3) @(negedge clock);
    chk("end_rdy", 32'(rdy), 1);
    chk("end_q", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vidac_enc.md
VIDAC_ENC -- requirements
Module: vidac_enc

Interface
REQ-001 Parameter MAXLEN, default 4096, command-buffer capacity in bytes, terminator byte included.
REQ-002 Parameter BASE, default 18'h20000, video-memory address of the command buffer.
REQ-003 clock  input  1  system clock.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 op  input  3  command code: 1=LINE, 2=BLOCK, 3=BLOCK_FILL, 4=POLY, 5=CIRCLE, 6=CIRCLE_FILL.
REQ-006 px1, py1, px2, py2  input  16 each  signed coordinates; CIRCLE uses px1/py1 as centre and px2 as radius.
REQ-007 pc  input  8  colour.
REQ-008 push  input  1  enqueue strobe.
REQ-009 flush  input  1  execute-list strobe.
REQ-010 rdy  output  1  block is idle and accepts push/flush.
REQ-011 err  output  1  one-cycle pulse when a push is rejected.
REQ-012 len  output  16  bytes currently queued, terminator excluded.
REQ-013 a  output  18  video-memory address.
REQ-014 o  output  8  video-memory write data.
REQ-015 w  output  1  video-memory write enable.
REQ-016 own  output  1  block drives the shared memory bus (external mux select).
REQ-017 cmd  output  1  start pulse to the accelerator.
REQ-018 bsy  input  1  accelerator busy.

Function
REQ-019 States: IDLE, EMIT, TERM, KICK, WAITB, WAITD; rdy=1 only in IDLE.
REQ-020 Record format, bytes little-endian: opcode, then LINE/BLOCK/BLOCK_FILL x1,y1,x2,y2,c (10 bytes); POLY x2,y2,c (6 bytes); CIRCLE/CIRCLE_FILL x,y,r,c (8 bytes). POLY takes x2,y2 from px2,py2.
REQ-021 Push accepted in IDLE: latch op and params; if ptr+n+1 <= MAXLEN, go to EMIT next cycle.
REQ-022 A push with op 0 or 7 sets err=1 for one cycle, writes nothing, and stays in IDLE.
REQ-023 A push that does not fit sets err=1 for one cycle and writes nothing (unless VIDAC_ENC_AUTOFLUSH_EN is defined).
REQ-024 EMIT: one byte per cycle; a=BASE+ptr, o=byte, w=1, own=1, ptr increments; after the last byte, go to IDLE, or to TERM if a flush is pending.
REQ-025 Flush in IDLE with ptr>0 goes to TERM; flush with ptr==0 is a no-op.
REQ-026 Push and flush in the same cycle: the push is processed first and the flush is held pending.
REQ-027 TERM: write 8'h00 at BASE+ptr with w=1 and own=1, then go to KICK.
REQ-028 KICK: cmd=1 for exactly one cycle, own=0, then go to WAITB.
REQ-029 WAITB: wait until bsy=1, then go to WAITD.
REQ-030 WAITD: wait until bsy=0, then set ptr=0 and go to IDLE.
REQ-031 cmd is never high in consecutive cycles.
REQ-032 w=0 whenever own=0.
REQ-033 No memory write occurs while bsy=1.
REQ-034 Push or flush outside IDLE is ignored; no err pulse is generated.
REQ-035 len equals ptr at all times.
REQ-036 ptr arithmetic is 16 bits; ptr never exceeds MAXLEN-1.

Reset
REQ-037 With reset_n=0 at a clock edge: state=IDLE, ptr=0, cmd=0, w=0, own=0, err=0, a=0, o=0, pending flush cleared.
REQ-038 Reset mid-EMIT or mid-WAIT aborts without further writes; buffer contents are not cleared.

Configuration
REQ-039 Macro VIDAC_ENC_AUTOFLUSH_EN defined: a push that does not fit performs TERM/KICK/WAITB/WAITD, then emits the held command at ptr=0, with no err pulse.
REQ-040 Macro VIDAC_ENC_AUTOFLUSH_EN not defined: REQ-023 applies.

Verification
REQ-041 LINE (1,2)-(300,-5) c=0x0F pushed -> writes at 0x20000..0x20009: 01 01 00 02 00 2C 01 FB FF 0F; len=10.
REQ-042 Then flush -> 00 written at 0x2000A, one-cycle cmd, bsy held 50 cycles -> rdy returns, len=0.
REQ-043 CIRCLE (160,100) r=40 c=7, then POLY (10,20) c=3, same-cycle flush -> 05 A0 00 64 00 28 00 07 04 0A 00 14 00 03 00.
REQ-044 push op=0 -> err pulse, no write; MAXLEN=16 with a second LINE -> err pulse, or autoflush with the record at 0x20000 when the macro is defined.
REQ-045 reset_n low during WAITD -> cmd=0, own=0, rdy=1, len=0 next cycle.
